// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    function automatic int unsigned ndig(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

    // A counter that never needs more than one value still gets one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// Combinational DIGIT-bit ripple of full-adder slices; exposes the carry into its top bit.
module serial_adder_digit #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_top
);

    logic carry;

    always_comb begin
        carry = ci;
        s     = '0;
        c_top = 1'b0;
        for (int i = 0; i < int'(DIGIT); i++) begin
            if (i == int'(DIGIT) - 1) c_top = carry;
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
        end
        co = carry;
    end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder with valid/ready handshakes on both sides.
// Optional subtract mode via define SERIAL_ADDER_SUB_EN (adds the subIn port).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cIn,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] sum,
    output logic             cOut,
    output logic             ovf,
    output logic             busy
`ifdef SERIAL_ADDER_SUB_EN
    ,
    input  logic             subIn
`endif
);

    localparam int unsigned NDIG  = ndig(WIDTH, DIGIT);
    localparam int unsigned CNT_W = cnt_width(NDIG);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
    end

    logic sub_sel;
`ifdef SERIAL_ADDER_SUB_EN
    assign sub_sel = subIn;
`else
    assign sub_sel = 1'b0;
`endif

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;

    int unsigned      base;
    logic [DIGIT-1:0] d_sum;
    logic             d_co;
    logic             d_ctop;

    always_comb base = 32'(cnt_q) * DIGIT;

    serial_adder_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a     (a_q[base +: DIGIT]),
        .b     (b_q[base +: DIGIT]),
        .ci    (carry_q),
        .s     (d_sum),
        .co    (d_co),
        .c_top (d_ctop)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            sum      <= '0;
            cOut     <= 1'b0;
            ovf      <= 1'b0;
            outValid <= 1'b0;
            busy     <= 1'b0;
            inReady  <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (inValid) begin
                        // Subtraction is a + ~b + 1; the inversion is folded in at latch time.
                        a_q     <= a;
                        b_q     <= sub_sel ? ~b : b;
                        carry_q <= sub_sel ? 1'b1 : cIn;
                        cnt_q   <= '0;
                        state_q <= StRun;
                        inReady <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                StRun: begin
                    sum[base +: DIGIT] <= d_sum;
                    carry_q            <= d_co;
                    cnt_q              <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q  <= StDone;
                        busy     <= 1'b0;
                        outValid <= 1'b1;
                        cOut     <= d_co;
                        ovf      <= d_co ^ d_ctop;
                    end
                end
                StDone: begin
                    if (outReady) begin
                        outValid <= 1'b0;
                        inReady  <= 1'b1;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench: DIGIT=1 and DIGIT=4 instances share stimulus; checks results, latency, stalls.
module tb_serial_adder;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] e_sum;
        logic       e_cout;
        logic       e_ovf;
    } vec_t;

    logic       clk;
    logic       rstN;
    logic       inValid;
    logic       outReady;
    logic [7:0] a;
    logic [7:0] b;
    logic       cIn;
    logic       sub_in;

    logic       in_ready1, out_valid1, cout1, ovf1, busy1;
    logic [7:0] sum1;
    logic       in_ready4, out_valid4, cout4, ovf4, busy4;
    logic [7:0] sum4;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    serial_adder #(
        .WIDTH (8),
        .DIGIT (1)
    ) u_dut1 (
        .clk      (clk),
        .rstN     (rstN),
        .inValid  (inValid),
        .inReady  (in_ready1),
        .a        (a),
        .b        (b),
        .cIn      (cIn),
        .outValid (out_valid1),
        .outReady (outReady),
        .sum      (sum1),
        .cOut     (cout1),
        .ovf      (ovf1),
        .busy     (busy1)
`ifdef SERIAL_ADDER_SUB_EN
        ,
        .subIn    (sub_in)
`endif
    );

    serial_adder #(
        .WIDTH (8),
        .DIGIT (4)
    ) u_dut4 (
        .clk      (clk),
        .rstN     (rstN),
        .inValid  (inValid),
        .inReady  (in_ready4),
        .a        (a),
        .b        (b),
        .cIn      (cIn),
        .outValid (out_valid4),
        .outReady (outReady),
        .sum      (sum4),
        .cOut     (cout4),
        .ovf      (ovf4),
        .busy     (busy4)
`ifdef SERIAL_ADDER_SUB_EN
        ,
        .subIn    (sub_in)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation to both instances, measure latency, check results, then drain.
    task automatic run_vec(input vec_t v, input int idx);
        int lat1, lat4;
        string tag;
        tag = $sformatf("v%0d", idx);
        a = v.a; b = v.b; cIn = v.cin; sub_in = v.sub;
        inValid = 1'b1; outReady = 1'b0;
        chk({tag, ".in_ready1"}, 32'(in_ready1), 32'd1);
        chk({tag, ".in_ready4"}, 32'(in_ready4), 32'd1);
        tick();
        inValid = 1'b0;
        a = 8'h5c; b = 8'hc5; cIn = ~v.cin;
        lat1 = -1; lat4 = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) chk({tag, ".busy1"}, 32'(busy1), 32'd1);
            if (out_valid1 && lat1 < 0) lat1 = c;
            if (out_valid4 && lat4 < 0) lat4 = c;
            if (lat1 >= 0 && lat4 >= 0) break;
        end
        chk({tag, ".lat1"}, 32'(lat1), 32'd8);
        chk({tag, ".lat4"}, 32'(lat4), 32'd2);
        chk({tag, ".sum1"}, 32'(sum1), 32'(v.e_sum));
        chk({tag, ".cout1"}, 32'(cout1), 32'(v.e_cout));
        chk({tag, ".ovf1"}, 32'(ovf1), 32'(v.e_ovf));
        chk({tag, ".sum4"}, 32'(sum4), 32'(v.e_sum));
        chk({tag, ".cout4"}, 32'(cout4), 32'(v.e_cout));
        chk({tag, ".ovf4"}, 32'(ovf4), 32'(v.e_ovf));
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        chk({tag, ".drain_ov1"}, 32'(out_valid1), 32'd0);
        chk({tag, ".drain_ir1"}, 32'(in_ready1), 32'd1);
        chk({tag, ".drain_ir4"}, 32'(in_ready4), 32'd1);
    endtask

    initial begin
        vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{8'hff, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'h7f, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{8'ha5, 8'h5a, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'h0f, 8'h01, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0});
        vecs.push_back('{8'h3c, 8'h4b, 1'b0, 1'b0, 8'h87, 1'b0, 1'b1});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{8'h05, 8'h07, 1'b1, 1'b1, 8'hfe, 1'b0, 1'b0});
        vecs.push_back('{8'h80, 8'h01, 1'b0, 1'b1, 8'h7f, 1'b1, 1'b1});
        vecs.push_back('{8'h09, 8'h03, 1'b0, 1'b1, 8'h06, 1'b1, 1'b0});
`endif

        rstN = 1'b0; inValid = 1'b0; outReady = 1'b0;
        a = '0; b = '0; cIn = 1'b0; sub_in = 1'b0;
        #12;
        chk("rst.in_ready", 32'(in_ready1), 32'd1);
        chk("rst.out_valid", 32'(out_valid1), 32'd0);
        chk("rst.busy", 32'(busy1), 32'd0);
        chk("rst.sum", 32'(sum1), 32'd0);
        chk("rst.cout_ovf", 32'({cout1, ovf1}), 32'd0);
        rstN = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Backpressure: stall DONE for 5 cycles while new operands are offered.
        a = 8'h12; b = 8'h34; cIn = 1'b0; sub_in = 1'b0; inValid = 1'b1;
        tick();
        inValid = 1'b0;
        for (int c = 0; c < 20 && !out_valid1; c++) tick();
        a = 8'hee; b = 8'hee; cIn = 1'b1; inValid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp.sum", 32'(sum1), 32'h46);
            chk("bp.cout", 32'(cout1), 32'd0);
            chk("bp.out_valid", 32'(out_valid1), 32'd1);
            chk("bp.in_ready", 32'(in_ready1), 32'd0);
        end
        inValid = 1'b0; outReady = 1'b1;
        tick();
        outReady = 1'b0;
        chk("bp.release_ir", 32'(in_ready1), 32'd1);
        chk("bp.release_ov", 32'(out_valid1), 32'd0);
        chk("bp.keep_sum", 32'(sum1), 32'h46);

        // Reset asserted mid-RUN, between clock edges.
        a = 8'hff; b = 8'hff; cIn = 1'b1; inValid = 1'b1;
        tick();
        inValid = 1'b0;
        tick(); tick(); tick();
        #2 rstN = 1'b0;
        #1;
        chk("mrst.sum", 32'(sum1), 32'd0);
        chk("mrst.busy", 32'(busy1), 32'd0);
        chk("mrst.in_ready", 32'(in_ready1), 32'd1);
        chk("mrst.out_valid4", 32'(out_valid4), 32'd0);
        chk("mrst.sum4", 32'(sum4), 32'd0);
        tick();
        rstN = 1'b1;
        tick();
        run_vec('{8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0}, 99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised multi-cycle adder built on the one-bit full-adder slice. Operands are latched through a valid/ready handshake. The block processes DIGIT bits per cycle, LSB first, and returns the result through a valid/ready handshake. It replaces wide combinational ripple adders in area-constrained datapaths and serves as a reusable arithmetic unit behind register-mapped or streaming front ends.

Parameters:
WIDTH, 8, operand and result width in bits; must be at least 1.
DIGIT, 1, bits processed per cycle; WIDTH must be an integer multiple of DIGIT (elaboration error otherwise).

Ports:
clk  input  1  single clock, rising edge
rstN  input  1  asynchronous active-low reset
inValid  input  1  operands a, b, cIn valid
inReady  output  1  block can accept operands
a  input  WIDTH  operand A (unsigned or two's complement)
b  input  WIDTH  operand B
cIn  input  1  carry into bit 0
outValid  output  1  sum, cOut, ovf valid
outReady  input  1  consumer accepts result
sum  output  WIDTH  result a+b+cIn modulo 2^WIDTH
cOut  output  1  carry out of bit WIDTH-1
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB
busy  output  1  high in RUN

Behaviour:
- Clock and reset: one clock (clk); reset rstN is asynchronous and active-low. Asserting rstN forces state IDLE immediately. Reset values: sum=0, cOut=0, ovf=0, outValid=0, busy=0, inReady=1, digit counter=0.
- NDIG = WIDTH/DIGIT.
- FSM states:
  - IDLE: inReady=1. A transfer occurs on the rising edge where inValid && inReady. On transfer, latch a, b and cIn into internal registers, clear the counter, and go to RUN.
  - RUN: inReady=0, busy=1. Each cycle, add digit[counter] of A and B with the running carry, write DIGIT sum bits into sum[counter*DIGIT +: DIGIT], update the carry, and increment the counter. After digit NDIG-1, go to DONE.
  - DONE: outValid=1. sum, cOut and ovf stay stable until outValid && outReady. On that edge: outValid goes to 0, state goes to IDLE, sum/cOut/ovf keep their last values.
- Latency: outValid rises exactly NDIG cycles after the accepting edge. Minimum issue interval is NDIG+2 cycles.
- Input acceptance: inValid is ignored outside IDLE. Operand inputs may change freely after acceptance.
- Output behaviour: outReady is ignored outside DONE. Holding outReady low stalls the block indefinitely with no loss of data.
- ovf is computed on the final digit from the carry into bit WIDTH-1 and the carry out of bit WIDTH-1, which requires per-bit carry visibility inside the digit slice. cOut is the final running carry.
- DIGIT = WIDTH degenerates to a single RUN cycle.
- Reset asserted mid-RUN or in DONE abandons the operation and applies the reset values. The next operation after reset release is unaffected.

Optional Feature:
SERIAL_ADDER_SUB_EN
- Defined: adds input port subIn (1 bit), latched with the operands. When subIn=1, B is bitwise inverted and the initial carry is forced to 1, so the result is a-b and cIn is ignored. cOut=1 means no borrow. ovf reports signed subtraction overflow.
- Undefined: no subIn port and addition only; behaviour is identical to subIn=0.

Decomposition:
- serial_adder_pkg holds:
  - the FSM state enum (IDLE, RUN, DONE)
  - a function returning NDIG
  - a counter-width constant function using clog2 of NDIG, minimum 1
- One sub-module: serial_adder_digit, a combinational DIGIT-bit ripple of full-adder slices. It outputs the DIGIT sum bits, the carry out, and the carry into its top bit (used for ovf).
- All registers and the FSM live in serial_adder.

Test Plan:
- WIDTH=8, DIGIT=1: a=0x00, b=0x00, cIn=0 -> outValid exactly 8 cycles after accept; sum=0x00, cOut=0, ovf=0.
- WIDTH=8, DIGIT=1: a=0xFF, b=0x01, cIn=0 -> sum=0x00, cOut=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, cOut=0, ovf=1.
- WIDTH=8, DIGIT=4: a=0xA5, b=0x5A, cIn=1 -> outValid 2 cycles after accept; sum=0x00, cOut=1, ovf=0.
- Backpressure: hold outReady=0 for 5 cycles in DONE -> sum, cOut and outValid stable, inReady=0, new inValid ignored. Raise outReady -> IDLE next cycle, inReady=1.
- Reset mid-RUN: assert rstN=0 asynchronously after 3 RUN cycles -> all outputs at reset values immediately. After release, a=0x03, b=0x04 -> sum=0x07.
- With SERIAL_ADDER_SUB_EN, WIDTH=8: subIn=1, a=0x05, b=0x07 -> sum=0xFE, cOut=0. Then a=0x80, b=0x01 -> sum=0x7F, ovf=1.
